// File: rtl/alu_pipe_n_if.sv
`default_nettype none
// ============================================================================
// alu_pipe_n_if : operand-in / result-out streaming bus for alu_pipe_n
// Revision      : 1.0
// ============================================================================
interface alu_pipe_n_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   C;
    logic             zero;
    logic             neg;
    logic             ovf;

    // Producer/consumer side of the ALU
    modport master (
        output in_valid, opcode, A, B, out_ready,
        input  in_ready, out_valid, C, zero, neg, ovf
    );

    // ALU side
    modport slave (
        input  in_valid, opcode, A, B, out_ready,
        output in_ready, out_valid, C, zero, neg, ovf
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_n.sv
`default_nettype none
// ============================================================================
// alu_pipe_n : two-stage pipelined signed ALU with accumulator, flags and
//              valid/ready handshakes. Optional saturation: ALU_PIPE_SAT_EN.
// Revision   : 1.0
// ============================================================================
module alu_pipe_n #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_pipe_n_if.slave bus
);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_not = 3'b010;
    localparam logic [2:0] c_op_orr = 3'b011;
    localparam logic [2:0] c_op_and = 3'b100;
    localparam logic [2:0] c_op_xor = 3'b101;
    localparam logic [2:0] c_op_acc = 3'b110;
    localparam logic [2:0] c_op_clr = 3'b111;

    localparam logic [WIDTH:0] c_sat_max = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0] c_sat_min = {2'b11, {(WIDTH-1){1'b0}}};

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s2_valid;
    logic [WIDTH:0]   r_c;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;
    logic [WIDTH:0]   r_acc;

    logic             w_s2_advance;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH+1:0] w_fit_add;
    logic [WIDTH+1:0] w_fit_sub;
    logic [WIDTH:0]   w_acc_sum;
    logic [WIDTH:0]   w_result;
    logic             w_ovf;
    logic [WIDTH:0]   w_acc_next;
`ifdef ALU_PIPE_SAT_EN
    logic [WIDTH+1:0] w_fit_acc;
`endif

    // Returns {overflow, value}: overflow means v does not fit in WIDTH signed
    // bits; under saturation the value is clamped to the WIDTH-bit range.
    function automatic logic [WIDTH+1:0] fit(input logic [WIDTH:0] v);
        logic narrow_ovf;
        narrow_ovf = v[WIDTH] ^ v[WIDTH-1];
`ifdef ALU_PIPE_SAT_EN
        if (narrow_ovf) begin
            return {1'b1, (v[WIDTH] ? c_sat_min : c_sat_max)};
        end
`endif
        return {narrow_ovf, v};
    endfunction

    assign w_s2_advance = !r_s2_valid || bus.out_ready;
    assign w_in_ready   = !r_s1_valid || w_s2_advance;
    assign w_in_fire    = bus.in_valid && w_in_ready;

    always_comb begin
        w_a_ext    = {r_s1_a[WIDTH-1], r_s1_a};
        w_b_ext    = {r_s1_b[WIDTH-1], r_s1_b};
        w_fit_add  = fit(w_a_ext + w_b_ext);
        w_fit_sub  = fit(w_a_ext - w_b_ext);
        w_acc_sum  = r_acc + w_a_ext;
`ifdef ALU_PIPE_SAT_EN
        w_fit_acc  = fit(w_acc_sum);
`endif
        w_result   = '0;
        w_ovf      = 1'b0;
        w_acc_next = r_acc;
        case (r_s1_op)
            c_op_add: begin
                w_result = w_fit_add[WIDTH:0];
                w_ovf    = w_fit_add[WIDTH+1];
            end
            c_op_sub: begin
                w_result = w_fit_sub[WIDTH:0];
                w_ovf    = w_fit_sub[WIDTH+1];
            end
            c_op_not: w_result = ~w_a_ext;
            c_op_orr: w_result = {{WIDTH{1'b0}}, |r_s1_b};
            c_op_and: w_result = w_a_ext & w_b_ext;
            c_op_xor: w_result = w_a_ext ^ w_b_ext;
            c_op_acc: begin
`ifdef ALU_PIPE_SAT_EN
                w_result = w_fit_acc[WIDTH:0];
                w_ovf    = w_fit_acc[WIDTH+1];
`else
                // Wrap detection on the full WIDTH+1-bit add
                w_result = w_acc_sum;
                w_ovf    = (r_acc[WIDTH] == w_a_ext[WIDTH]) &&
                           (w_acc_sum[WIDTH] != r_acc[WIDTH]);
`endif
                w_acc_next = w_result;
            end
            c_op_clr: w_acc_next = '0;
            default:  w_result   = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_c        <= '0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= bus.opcode;
                r_s1_a     <= bus.A;
                r_s1_b     <= bus.B;
            end else if (w_s2_advance) begin
                r_s1_valid <= 1'b0;
            end

            // Accumulator commits only on the stage-1 to stage-2 move
            if (w_s2_advance) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_c    <= w_result;
                    r_zero <= (w_result == '0);
                    r_neg  <= w_result[WIDTH];
                    r_ovf  <= w_ovf;
                    r_acc  <= w_acc_next;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.C         = r_c;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
